// File: rtl/rv32imc_types.sv
// Shared operation encodings for the rv32imc execute stage.
// Holds the ALU, compare and multiply/divide operation enums plus small decode
// helpers used by the execute units.
package rv32imc_types;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

   typedef enum logic [2:0] {
      CMP_EQ  = 3'd0,
      CMP_NE  = 3'd1,
      CMP_LT  = 3'd4,
      CMP_GE  = 3'd5,
      CMP_LTU = 3'd6,
      CMP_GEU = 3'd7
   } cmp_op_t;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } muldiv_op_t;

   function automatic logic md_is_div(input muldiv_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
   endfunction

   function automatic logic md_is_rem(input muldiv_op_t op);
      return (op == MD_REM) || (op == MD_REMU);
   endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One result bit per cycle: shift-add multiply, restoring divide, both on
// operand magnitudes with sign fix-up applied once at the end.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_start        request a new operation (taken only when idle)
//   i_op           MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   i_a, i_b       rs1 / rs2 operands
//   i_flush        abort the operation in flight
//   o_busy         unit is computing or finishing
//   o_valid        one-cycle result strobe
//   o_result       result, held until the next completed operation
module ex_muldiv
   import rv32imc_types::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  muldiv_op_t      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  logic            i_flush,
   output logic            o_busy,
   output logic            o_valid,
   output logic [XLEN-1:0] o_result
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   muldiv_op_t       op_q, op_d;
   // Multiply: acc_hi = running high half, acc_lo = multiplier shifting out / product low half.
   // Divide:   acc_hi = partial remainder, acc_lo = dividend shifting out / quotient shifting in.
   logic [XLEN-1:0]  acc_hi_q, acc_hi_d;
   logic [XLEN-1:0]  acc_lo_q, acc_lo_d;
   logic [XLEN-1:0]  mcand_q, mcand_d;
   logic             neg_q, neg_d;
   logic             neg_rem_q, neg_rem_d;
   logic             bypass_q, bypass_d;
   logic             valid_q, valid_d;
   logic [XLEN-1:0]  result_q, result_d;

   // Operand decode for the accepting cycle
   logic            in_div, in_rem, a_signed, b_signed, a_neg, b_neg;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] a_mag, b_mag, special_res;

   always_comb begin
      in_div   = md_is_div(i_op);
      in_rem   = md_is_rem(i_op);
      a_signed = (i_op == MD_MULH) || (i_op == MD_MULHSU) || (i_op == MD_DIV) || (i_op == MD_REM);
      b_signed = (i_op == MD_MULH) || (i_op == MD_DIV) || (i_op == MD_REM);
      a_neg    = a_signed & i_a[XLEN-1];
      b_neg    = b_signed & i_b[XLEN-1];
      a_mag    = a_neg ? -i_a : i_a;
      b_mag    = b_neg ? -i_b : i_b;
      div_zero = in_div && (i_b == '0);
      // Most-negative / -1 overflows the quotient; its answer is known up front.
      div_ovf  = in_div && a_signed && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);
      if (div_zero) begin
         special_res = in_rem ? i_a : '1;
      end else begin
         special_res = in_rem ? '0 : i_a;
      end
   end

   // One iteration of the shared datapath
   logic [XLEN:0]   mul_sum, div_shift, div_diff;
   logic [XLEN-1:0] step_hi, step_lo;

   always_comb begin
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
      div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, mcand_q};
      if (md_is_div(op_q)) begin
         // Borrow out (top bit) means the trial subtraction failed: restore.
         if (!div_diff[XLEN]) begin
            step_hi = div_diff[XLEN-1:0];
            step_lo = {acc_lo_q[XLEN-2:0], 1'b1};
         end else begin
            step_hi = div_shift[XLEN-1:0];
            step_lo = {acc_lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
      end
   end

   // Sign post-correction and result selection
   logic [2*XLEN-1:0] prod_abs, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

   always_comb begin
      prod_abs = {acc_hi_q, acc_lo_q};
      prod_fix = neg_q ? -prod_abs : prod_abs;
      quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
      rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;
      case (op_q)
         MD_MUL:                        final_res = prod_fix[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:               final_res = quo_fix;
         default:                       final_res = rem_fix;
      endcase
      if (bypass_q) begin
         final_res = acc_lo_q;
      end
   end

   // Next-state and control
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      mcand_d   = mcand_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      bypass_d  = bypass_q;
      result_d  = result_q;
      // Strobe one cycle after DONE; a flush during DONE does not cancel it.
      valid_d   = (state_q == S_DONE);

      case (state_q)
         S_IDLE: begin
            if (i_start && !i_flush) begin
               op_d      = i_op;
               cnt_d     = '0;
               neg_d     = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               acc_hi_d  = '0;
               if (div_zero || div_ovf) begin
                  state_d  = S_DONE;
                  bypass_d = 1'b1;
                  acc_lo_d = special_res;
               end else begin
                  state_d  = S_CALC;
                  bypass_d = 1'b0;
                  acc_lo_d = in_div ? a_mag : b_mag;
                  mcand_d  = in_div ? b_mag : a_mag;
               end
            end
         end
         S_CALC: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
            end
            if (i_flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            result_d = final_res;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= MD_MUL;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         mcand_q   <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         bypass_q  <= 1'b0;
         valid_q   <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         mcand_q   <= mcand_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         bypass_q  <= bypass_d;
         valid_q   <= valid_d;
         result_q  <= result_d;
      end
   end

   assign o_busy   = (state_q == S_CALC) || (state_q == S_DONE);
   assign o_valid  = valid_q;
   assign o_result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
   import rv32imc_types::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start32, flush32, busy32, valid32;
   muldiv_op_t  op32;
   logic [31:0] a32, b32, res32;
   logic        start16, flush16, busy16, valid16;
   muldiv_op_t  op16;
   logic [15:0] a16, b16, res16;

   int checks   = 0;
   int failures = 0;
   logic [31:0] last_exp32, last_exp16;

   always #5 clk = ~clk;

   ex_muldiv #(.XLEN(32)) dut32 (
      .clk(clk), .rst(rst), .i_start(start32), .i_op(op32), .i_a(a32), .i_b(b32),
      .i_flush(flush32), .o_busy(busy32), .o_valid(valid32), .o_result(res32)
   );

   ex_muldiv #(.XLEN(16)) dut16 (
      .clk(clk), .rst(rst), .i_start(start16), .i_op(op16), .i_a(a16), .i_b(b16),
      .i_flush(flush16), .o_busy(busy16), .o_valid(valid16), .o_result(res16)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural reference: plain wide arithmetic on the RISC-V M rules.
   function automatic logic [63:0] ref_model(input int xlen, input muldiv_op_t op,
                                             input logic [31:0] a, input logic [31:0] b);
      longint unsigned mask, ua, ub;
      longint          sa, sb, p, minv;
      logic [63:0]     r;
      mask = (64'd1 << xlen) - 64'd1;
      ua   = {32'b0, a} & mask;
      ub   = {32'b0, b} & mask;
      sa   = $signed(ua << (64 - xlen)) >>> (64 - xlen);
      sb   = $signed(ub << (64 - xlen)) >>> (64 - xlen);
      minv = -(longint'(1) <<< (xlen - 1));
      r    = '0;
      case (op)
         MD_MUL:    r = ua * ub;
         MD_MULH:   begin p = sa * sb;          r = p >>> xlen; end
         MD_MULHSU: begin p = sa * $signed(ub); r = p >>> xlen; end
         MD_MULHU:  r = (ua * ub) >> xlen;
         MD_DIV: begin
            if (ub == 0)                      r = mask;
            else if (sa == minv && sb == -1)  r = ua;
            else begin p = sa / sb; r = p; end
         end
         MD_DIVU: begin
            if (ub == 0) r = mask;
            else         r = ua / ub;
         end
         MD_REM: begin
            if (ub == 0)                      r = ua;
            else if (sa == minv && sb == -1)  r = '0;
            else begin p = sa % sb; r = p; end
         end
         default: begin
            if (ub == 0) r = ua;
            else         r = ua % ub;
         end
      endcase
      return r & mask;
   endfunction

   function automatic int ref_latency(input int xlen, input muldiv_op_t op,
                                      input logic [31:0] a, input logic [31:0] b);
      longint unsigned mask, ua, ub;
      bit is_div, is_sdiv;
      mask    = (64'd1 << xlen) - 64'd1;
      ua      = {32'b0, a} & mask;
      ub      = {32'b0, b} & mask;
      is_div  = (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
      is_sdiv = (op == MD_DIV) || (op == MD_REM);
      if (is_div && ub == 0) return 1;
      if (is_sdiv && ua == (64'd1 << (xlen - 1)) && ub == mask) return 1;
      return xlen + 1;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'($urandom_range(1, 20));
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic drive(input bit w16, input logic st, input logic fl, input muldiv_op_t op,
                        input logic [31:0] a, input logic [31:0] b);
      if (w16) begin
         start16 = st; flush16 = fl; op16 = op; a16 = a[15:0]; b16 = b[15:0];
      end else begin
         start32 = st; flush32 = fl; op32 = op; a32 = a; b32 = b;
      end
   endtask

   function automatic logic get_valid(input bit w16);
      return w16 ? valid16 : valid32;
   endfunction

   function automatic logic get_busy(input bit w16);
      return w16 ? busy16 : busy32;
   endfunction

   function automatic logic [31:0] get_result(input bit w16);
      return w16 ? {16'b0, res16} : res32;
   endfunction

   // Issue one operation (starting in the next cycle) and check latency, busy and result.
   task automatic run_op(input bit w16, input string tag, input muldiv_op_t op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
      int n;
      bit got, busy_bad;
      @(negedge clk);
      drive(w16, 1'b1, 1'b0, op, a, b);
      @(posedge clk);
      #1;
      // Scramble the inputs: the operation must use the captured values.
      drive(w16, 1'b0, 1'b0, muldiv_op_t'($urandom_range(0, 7)), $urandom, $urandom);
      check({tag, "_acc_busy"}, 64'(get_busy(w16)), 64'd1);
      check({tag, "_acc_novalid"}, 64'(get_valid(w16)), 64'd0);
      n = 0; got = 0; busy_bad = 0;
      while (!got && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (get_valid(w16)) got = 1;
         else if (!get_busy(w16)) busy_bad = 1;
      end
      check({tag, "_lat"}, 64'(n), 64'(lat));
      check({tag, "_busy"}, 64'(busy_bad), 64'd0);
      check({tag, "_res"}, 64'(get_result(w16)), 64'(exp));
      if (w16) last_exp16 = exp;
      else     last_exp32 = exp;
   endtask

   task automatic run_rand(input bit w16);
      muldiv_op_t  op;
      logic [31:0] a, b;
      logic [63:0] e;
      int          xlen;
      xlen = w16 ? 16 : 32;
      op   = muldiv_op_t'($urandom_range(0, 7));
      a    = rand_operand();
      b    = rand_operand();
      if (w16) begin
         a = {16'b0, a[15:0]};
         b = {16'b0, b[15:0]};
         if (a == 32'h0000_0000 && $urandom_range(0, 1) == 1) a = 32'h0000_8000;
      end
      e = ref_model(xlen, op, a, b);
      run_op(w16, $sformatf("rnd%0d_%s_%h_%h", xlen, op.name(), a, b), op, a, b,
             e[31:0], ref_latency(xlen, op, a, b));
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int vcount;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, MD_MUL, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, MD_MUL, 32'h0, 32'h0);
      last_exp32 = '0;
      last_exp16 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy32", 64'(busy32), 64'd0);
      check("rst_valid32", 64'(valid32), 64'd0);
      check("rst_res32", 64'(res32), 64'd0);
      check("rst_busy16", 64'(busy16), 64'd0);
      check("rst_valid16", 64'(valid16), 64'd0);
      check("rst_res16", 64'(res16), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed values, back to back
      run_op(0, "mul_7_m3",     MD_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op(0, "mulhu_m1",     MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op(0, "mulh_m1",      MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_op(0, "mulhsu_m1",    MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run_op(0, "div_m7_2",     MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      run_op(0, "rem_m7_2",     MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      run_op(0, "divu_100_7",   MD_DIVU,   32'd100,       32'd7,         32'd14,        33);
      run_op(0, "remu_100_7",   MD_REMU,   32'd100,       32'd7,         32'd2,         33);
      run_op(0, "divu_by0",     MD_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1);
      run_op(0, "remu_by0",     MD_REMU,   32'd100,       32'd0,         32'd100,       1);
      run_op(0, "div_by0",      MD_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);
      run_op(0, "rem_by0",      MD_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);
      run_op(0, "div_ovf",      MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op(0, "rem_ovf",      MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      run_op(0, "divu_min_m1",  MD_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_op(16'd1, "mul16_7_m3", MD_MUL,  32'd7,         32'h0000_FFFD, 32'h0000_FFEB, 17);

      // Flush in the tenth CALC cycle
      @(negedge clk);
      drive(0, 1'b1, 1'b0, MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, MD_MUL, 32'h0, 32'h0);
      repeat (10) @(negedge clk);
      flush32 = 1'b1;
      @(posedge clk);
      #1;
      check("flush_busy", 64'(busy32), 64'd0);
      check("flush_valid", 64'(valid32), 64'd0);
      check("flush_res_kept", 64'(res32), 64'(last_exp32));
      run_op(0, "after_flush", MD_DIVU, 32'd1000, 32'd33, 32'd30, 33);

      // Reset in the middle of CALC discards the operation
      @(negedge clk);
      drive(0, 1'b1, 1'b0, MD_MUL, 32'd3, 32'd5);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, MD_MUL, 32'h0, 32'h0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_busy", 64'(busy32), 64'd0);
      check("midrst_valid", 64'(valid32), 64'd0);
      check("midrst_res", 64'(res32), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      last_exp32 = '0;
      last_exp16 = '0;
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (valid32) vcount++;
      end
      check("midrst_no_valid", 64'(vcount), 64'd0);

      // Flush and start together: start is not taken
      @(negedge clk);
      drive(0, 1'b1, 1'b1, MD_MUL, 32'd3, 32'd5);
      @(posedge clk);
      #1;
      check("flushstart_busy", 64'(busy32), 64'd0);
      drive(0, 1'b0, 1'b0, MD_MUL, 32'h0, 32'h0);
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (valid32) vcount++;
      end
      check("flushstart_no_valid", 64'(vcount), 64'd0);
      check("flushstart_res", 64'(res32), 64'(last_exp32));

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) run_rand(1'b0);
      for (int i = 0; i < 12; i++) run_rand(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width in bits; legal values 8..64, power of two.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_start  input  1  request new operation.
REQ-005 SHALL have port i_op  input  muldiv_op_t (3)  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-006 SHALL have port i_a  input  XLEN  rs1 operand, already forwarded.
REQ-007 SHALL have port i_b  input  XLEN  rs2 operand, already forwarded.
REQ-008 SHALL have port i_flush  input  1  abort current operation (branch flush).
REQ-009 SHALL have port o_busy  output  1  high in CALC and DONE; EX stage stalls on o_busy & ~o_valid.
REQ-010 SHALL have port o_valid  output  1  single-cycle result strobe.
REQ-011 SHALL have port o_result  output  XLEN  result; held stable from o_valid until next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL accept i_start only in IDLE; ignore i_start in CALC/DONE.
REQ-014 SHALL capture i_op, i_a, i_b on the accepting edge; later input changes have no effect.
REQ-015 IDLE->CALC on accepted start; CALC->DONE when iteration counter reaches XLEN-1; DONE->IDLE unconditionally.
REQ-016 SHALL process one bit per CALC cycle: shift-add multiply, restoring divide.
REQ-017 Normal latency: o_valid high exactly XLEN+1 cycles after the edge that accepted i_start.
REQ-018 Multiply SHALL form a 2*XLEN product; MUL returns low XLEN bits, MULH/MULHSU/MULHU return high XLEN bits.
REQ-019 MULH: both operands signed. MULHSU: i_a signed, i_b unsigned. MULHU: both unsigned.
REQ-020 Signed divide SHALL operate on magnitudes. Quotient negated iff operand signs differ. Remainder takes the dividend sign. Quotient truncates toward zero.
REQ-021 Divide by zero SHALL skip CALC and go IDLE->DONE, so o_valid is high 1 cycle after accept. Results: quotient all ones; remainder = i_a (DIV, DIVU, REM, REMU).
REQ-022 DIV/REM with i_a = -2^(XLEN-1) and i_b = -1 SHALL skip CALC the same way. Quotient = i_a; remainder = 0.
REQ-023 i_flush in any state SHALL force IDLE on the next edge. It suppresses o_valid and leaves o_result unchanged.
REQ-024 i_flush and i_start in the same cycle: flush wins, start not accepted.
REQ-025 i_flush in DONE SHALL not deassert that cycle's o_valid. It only prevents further state change.
REQ-026 A back-to-back start SHALL be accepted in the first IDLE cycle after DONE.
REQ-027 o_valid SHALL be a registered decode of DONE, with no combinational path from inputs.

Reset
REQ-028 rst SHALL take priority over i_flush and i_start.
REQ-029 On rst: state IDLE, counter 0, o_busy 0, o_valid 0, o_result 0, internal accumulators 0.
REQ-030 rst mid-CALC SHALL discard the operation; no o_valid follows.

Structure
REQ-031 muldiv_op_t (3-bit enum) SHALL live in rv32imc_types, next to the existing ALU/CMP op types.
REQ-032 The FSM state enum SHALL be local to the module.
REQ-033 SHALL be a single module with no sub-module. Sign pre- and post-correction is inline combinational logic.
REQ-034 Counter width SHALL be $clog2(XLEN).

Verification
REQ-035 MUL, 7 x 0xFFFFFFFD (XLEN=32) -> o_result 0xFFFFFFEB; o_valid exactly 33 cycles after accept; o_busy high throughout.
REQ-036 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-037 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
REQ-038 DIVU 100 / 0 -> 0xFFFFFFFF and REMU 100 / 0 -> 100, each with o_valid 1 cycle after accept. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, also 1 cycle.
REQ-039 i_flush at CALC cycle 10 -> IDLE next cycle, no o_valid, o_result keeps its prior value. A new start the following cycle completes normally.
REQ-040 rst asserted mid-CALC, and flush+start in the same cycle -> all outputs 0 / start ignored. Repeat REQ-035 with XLEN=16: latency 17 cycles.
